// File: rtl/wishbone_pkg.sv
// Shared Wishbone helpers: width arithmetic for FIFO occupancy counters.
package wishbone_pkg;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned LEVEL_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wishbone_fifo_target_if.sv
// Wishbone B4 classic bus bundle between controller (master) and FIFO target (slave).
interface wishbone_fifo_target_if #(
  parameter int unsigned DAT_WIDTH = 8
);
  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [DAT_WIDTH-1:0] dat_i;
  logic [DAT_WIDTH-1:0] dat_o;
  logic                 ack_o;

  modport master (
    output cyc_i, stb_i, we_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; full/empty derive from the registered level only.
module sync_fifo
  import wishbone_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push,
  input  logic [DAT_WIDTH-1:0]      push_data,
  input  logic                      pop,
  output logic [DAT_WIDTH-1:0]      head,
  output logic                      full,
  output logic                      empty,
  output logic [LEVEL_W(DEPTH)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = LEVEL_W(DEPTH);

  logic [DAT_WIDTH-1:0] mem_q [DEPTH];
  logic [DAT_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/wishbone_fifo_target.sv
// Wishbone classic target: bus writes feed a TX stream FIFO, bus reads drain an RX stream FIFO.
module wishbone_fifo_target
  import wishbone_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  wishbone_fifo_target_if.slave     bus,
  output logic [DAT_WIDTH-1:0]      tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [DAT_WIDTH-1:0]      rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [LEVEL_W(DEPTH)-1:0] tx_level,
  output logic [LEVEL_W(DEPTH)-1:0] rx_level
);

  logic                 ack_q, ack_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 req, wr_acc, rd_acc;
  logic                 tx_full, tx_empty, tx_pop;
  logic                 rx_full, rx_empty, rx_push;
  logic [DAT_WIDTH-1:0] rx_head;

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  sync_fifo #(.DAT_WIDTH(DAT_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (wr_acc),
    .push_data (bus.dat_i),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  sync_fifo #(.DAT_WIDTH(DAT_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rd_acc),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  // Masking with ack_q forces a one-cycle gap so a held strobe completes once per two cycles.
  always_comb begin
    req    = bus.cyc_i & bus.stb_i & ~ack_q;
    wr_acc = req & bus.we_i & ~tx_full;
    rd_acc = req & ~bus.we_i & ~rx_empty;
    ack_d  = wr_acc | rd_acc;
    dat_d  = rd_acc ? rx_head : dat_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_wishbone_fifo_target.sv
// Directed bench for wishbone_fifo_target with a queue-based scoreboard on read data and TX stream.
module tb_wishbone_fifo_target;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] rx_model[$];

  wishbone_fifo_target_if #(.DAT_WIDTH(DW)) bus ();

  wishbone_fifo_target #(.DAT_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_level (tx_level),
    .rx_level (rx_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares read data on each read ack and TX head on each local pop.
  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    if (!rst) begin
      if (bus.ack_o && !bus.we_i) begin
        if (rd_q.size() == 0) check("rd_unexpected_ack", {31'b0, bus.ack_o}, 32'd0);
        else begin
          e = rd_q.pop_front();
          check("rd_data", {24'b0, bus.dat_o}, {24'b0, e});
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected_pop", {31'b0, tx_valid}, 32'd0);
        else begin
          e = tx_q.pop_front();
          check("tx_data", {24'b0, tx_data}, {24'b0, e});
        end
      end
    end
  end

  task automatic bus_write(input logic [DW-1:0] d, output int lat);
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.dat_i = d;
    tx_q.push_back(d);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ack_o) begin lat = i; break; end
    end
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
  endtask

  task automatic bus_read(input logic [DW-1:0] e, output int lat);
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
    rd_q.push_back(e);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ack_o) begin lat = i; break; end
    end
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
  endtask

  task automatic drain_tx(input int n);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.dat_i = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, bus.ack_o}, 32'd0);
    check("rst_dat_o", {24'b0, bus.dat_o}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("rst_tx_level", {29'b0, tx_level}, 32'd0);
    check("rst_rx_level", {29'b0, rx_level}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write, zero wait states
    bus_write(8'hA5, lat);
    check("wr_a5_latency", lat, 32'd2);
    @(negedge clk);
    check("wr_a5_tx_valid", {31'b0, tx_valid}, 32'd1);
    check("wr_a5_tx_data", {24'b0, tx_data}, 32'hA5);
    check("wr_a5_tx_level", {29'b0, tx_level}, 32'd1);
    check("wr_a5_ack_low", {31'b0, bus.ack_o}, 32'd0);
    drain_tx(1);
    @(negedge clk);
    check("drain_a5_level", {29'b0, tx_level}, 32'd0);

    // Fill TX, fifth write waits until one local pop
    for (int i = 1; i <= 4; i++) begin
      bus_write(8'(i), lat);
      check("fill_latency", lat, 32'd2);
    end
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.dat_i = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_wait_ack", {31'b0, bus.ack_o}, 32'd0);
      check("full_wait_level", {29'b0, tx_level}, 32'd4);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("full_pop_cycle_ack", {31'b0, bus.ack_o}, 32'd0);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("full_after_pop_ack", {31'b0, bus.ack_o}, 32'd0);
    check("full_after_pop_level", {29'b0, tx_level}, 32'd3);
    @(negedge clk);
    check("fifth_ack", {31'b0, bus.ack_o}, 32'd1);
    check("fifth_level", {29'b0, tx_level}, 32'd4);
    tx_q.push_back(8'h05);
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    drain_tx(4);

    // Read waits on empty RX until producer pushes
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rx_empty_wait_ack", {31'b0, bus.ack_o}, 32'd0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h3C;
    rd_q.push_back(8'h3C);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("rx_push_cycle_ack", {31'b0, bus.ack_o}, 32'd0);
    check("rx_push_level", {29'b0, rx_level}, 32'd1);
    @(negedge clk);
    check("rx_read_ack", {31'b0, bus.ack_o}, 32'd1);
    check("rx_read_level", {29'b0, rx_level}, 32'd0);
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;

    // Held strobe, back-to-back writes ack on alternate cycles
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.dat_i = 8'h10;
    tx_q.push_back(8'h10); tx_q.push_back(8'h11); tx_q.push_back(8'h12);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("b2b_ack", {31'b0, bus.ack_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) begin
        @(posedge clk); #1;
        if (k == 2) bus.dat_i = 8'h11;
        else if (k == 4) bus.dat_i = 8'h12;
        else begin bus.cyc_i = 1'b0; bus.stb_i = 1'b0; end
      end
    end
    drain_tx(3);

    // Simultaneous push/pop at level 2 on both FIFOs, wrapping pointers
    bus_write(8'h20, lat);
    check("pp_fill_latency", lat, 32'd2);
    bus_write(8'h21, lat);
    check("pp_fill_latency", lat, 32'd2);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h40; rx_model.push_back(8'h40);
    @(posedge clk); #1;
    rx_data = 8'h41; rx_model.push_back(8'h41);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      @(posedge clk); #1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
      bus.dat_i = 8'(32'h50 + i); tx_ready = 1'b1;
      tx_q.push_back(8'(32'h50 + i));
      @(posedge clk); #1;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; tx_ready = 1'b0;
      @(negedge clk);
      check("pp_tx_ack", {31'b0, bus.ack_o}, 32'd1);
      check("pp_tx_level", {29'b0, tx_level}, 32'd2);
      @(posedge clk); #1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
      rx_valid = 1'b1; rx_data = 8'(32'h60 + i);
      rd_q.push_back(rx_model.pop_front());
      rx_model.push_back(8'(32'h60 + i));
      @(posedge clk); #1;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; rx_valid = 1'b0;
      @(negedge clk);
      check("pp_rx_ack", {31'b0, bus.ack_o}, 32'd1);
      check("pp_rx_level", {29'b0, rx_level}, 32'd2);
    end
    drain_tx(2);
    for (int i = 0; i < 2; i++) begin
      bus_read(rx_model.pop_front(), lat);
      check("pp_tail_read_latency", lat, 32'd2);
    end

    // Asynchronous reset during a read wait state with TX at level 3
    for (int i = 0; i < 3; i++) begin
      bus_write(8'(32'h70 + i), lat);
      check("pre_rst_latency", lat, 32'd2);
    end
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
    @(negedge clk);
    check("pre_rst_wait_ack", {31'b0, bus.ack_o}, 32'd0);
    check("pre_rst_tx_level", {29'b0, tx_level}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ack", {31'b0, bus.ack_o}, 32'd0);
    check("arst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("arst_tx_level", {29'b0, tx_level}, 32'd0);
    check("arst_rx_level", {29'b0, rx_level}, 32'd0);
    check("arst_dat_o", {24'b0, bus.dat_o}, 32'd0);
    check("arst_rx_ready", {31'b0, rx_ready}, 32'd1);
    tx_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h99;
    rd_q.push_back(8'h99);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("post_rst_wait_ack", {31'b0, bus.ack_o}, 32'd0);
    @(negedge clk);
    check("post_rst_read_ack", {31'b0, bus.ack_o}, 32'd1);
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;

    bus_write(8'h77, lat);
    check("post_rst_wr_latency", lat, 32'd2);
    drain_tx(1);

    @(negedge clk);
    check("tx_scoreboard_empty", tx_q.size(), 32'd0);
    check("rd_scoreboard_empty", rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
